// File: rtl/mult_pipe_unit.sv
// Pipelined RV32M multiply unit: MUL/MULH/MULHSU/MULHU with stall, squash,
// x0 filtering and destination tracking for the hazard/stall controller.
module mult_pipe_unit #(
    parameter int XLEN   = 32,
    parameter int STAGES = 3,
    parameter int CNT_W  = $clog2(STAGES + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                use_i,
    input  logic [1:0]          mult_type_i,
    input  logic [XLEN-1:0]     rs1_data_i,
    input  logic [XLEN-1:0]     rs2_data_i,
    input  logic [4:0]          rd_addr_i,
    input  logic                stall_i,
    input  logic                squash_i,
    input  logic [4:0]          rs1_q_i,
    input  logic [4:0]          rs2_q_i,
    output logic                valid_o,
    output logic [4:0]          rd_addr_o,
    output logic [XLEN-1:0]     rd_data_o,
    output logic [31:0]         rd_flags_o,
    output logic                hazard_o,
    output logic [CNT_W-1:0]    inflight_cnt_o
);

    logic                accept;
    logic                a_sign;
    logic                b_sign;
    logic [2*XLEN-1:0]   a_wide;
    logic [2*XLEN-1:0]   b_wide;
    logic [2*XLEN-1:0]   prod;
    logic [XLEN-1:0]     result;
    logic [4:0]          rd_d;
    logic [XLEN-1:0]     data_d;

    logic                valid_q [STAGES];
    logic [4:0]          rd_q    [STAGES];
    logic [XLEN-1:0]     data_q  [STAGES];

    logic [31:0]         rd_flags;
    logic [CNT_W-1:0]    inflight_cnt;

    assign accept = use_i & ~stall_i & ~squash_i & (rd_addr_i != 5'd0);

    // Operands sign-extended to 2*XLEN: the low 2*XLEN product bits then equal
    // those of the (XLEN+1)x(XLEN+1) signed product.
    assign a_sign = rs1_data_i[XLEN-1] & (mult_type_i != 2'b11);
    assign b_sign = rs2_data_i[XLEN-1] & ~mult_type_i[1];
    assign a_wide = {{XLEN{a_sign}}, rs1_data_i};
    assign b_wide = {{XLEN{b_sign}}, rs2_data_i};
    assign prod   = a_wide * b_wide;

    assign result = (mult_type_i == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    assign rd_d   = accept ? rd_addr_i : 5'd0;
    assign data_d = accept ? result : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                valid_q[k] <= 1'b0;
                rd_q[k]    <= 5'd0;
                data_q[k]  <= '0;
            end
        end else if (!stall_i) begin
            valid_q[0] <= accept;
            rd_q[0]    <= rd_d;
            data_q[0]  <= data_d;
            for (int k = 1; k < STAGES; k++) begin
                valid_q[k] <= valid_q[k-1];
                rd_q[k]    <= rd_q[k-1];
                data_q[k]  <= data_q[k-1];
            end
        end
    end

    always_comb begin
        rd_flags     = 32'd0;
        inflight_cnt = '0;
        for (int k = 0; k < STAGES; k++) begin
            if (valid_q[k]) begin
                rd_flags[rd_q[k]] = 1'b1;
            end
            inflight_cnt = inflight_cnt + CNT_W'(valid_q[k]);
        end
        rd_flags[0] = 1'b0;
    end

    assign valid_o        = valid_q[STAGES-1];
    assign rd_addr_o      = valid_q[STAGES-1] ? rd_q[STAGES-1] : 5'd0;
    assign rd_data_o      = valid_q[STAGES-1] ? data_q[STAGES-1] : '0;
    assign rd_flags_o     = rd_flags;
    assign hazard_o       = rd_flags[rs1_q_i] | rd_flags[rs2_q_i];
    assign inflight_cnt_o = inflight_cnt;

endmodule

// File: tb/tb_mult_pipe_unit.sv
// Directed bench for mult_pipe_unit (XLEN=32, STAGES=3) with hand-computed
// expected values.
module tb_mult_pipe_unit;

    logic        clk;
    logic        rst;
    logic        use_i;
    logic [1:0]  mult_type_i;
    logic [31:0] rs1_data_i;
    logic [31:0] rs2_data_i;
    logic [4:0]  rd_addr_i;
    logic        stall_i;
    logic        squash_i;
    logic [4:0]  rs1_q_i;
    logic [4:0]  rs2_q_i;
    logic        valid_o;
    logic [4:0]  rd_addr_o;
    logic [31:0] rd_data_o;
    logic [31:0] rd_flags_o;
    logic        hazard_o;
    logic [1:0]  inflight_cnt_o;

    int n_tests = 0;
    int n_fail  = 0;

    mult_pipe_unit #(.XLEN(32), .STAGES(3)) dut (
        .clk            (clk),
        .rst            (rst),
        .use_i          (use_i),
        .mult_type_i    (mult_type_i),
        .rs1_data_i     (rs1_data_i),
        .rs2_data_i     (rs2_data_i),
        .rd_addr_i      (rd_addr_i),
        .stall_i        (stall_i),
        .squash_i       (squash_i),
        .rs1_q_i        (rs1_q_i),
        .rs2_q_i        (rs2_q_i),
        .valid_o        (valid_o),
        .rd_addr_o      (rd_addr_o),
        .rd_data_o      (rd_data_o),
        .rd_flags_o     (rd_flags_o),
        .hazard_o       (hazard_o),
        .inflight_cnt_o (inflight_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] t, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
        use_i       = 1'b1;
        mult_type_i = t;
        rs1_data_i  = a;
        rs2_data_i  = b;
        rd_addr_i   = rd;
    endtask

    task automatic idle();
        use_i       = 1'b0;
        mult_type_i = 2'b00;
        rs1_data_i  = 32'd0;
        rs2_data_i  = 32'd0;
        rd_addr_i   = 5'd0;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [4:0] rd,
                             input logic [31:0] d, input logic [31:0] fl, input logic [1:0] cnt);
        check({tag, ".valid"}, 64'(valid_o), 64'(v));
        check({tag, ".rd"},    64'(rd_addr_o), 64'(rd));
        check({tag, ".data"},  64'(rd_data_o), 64'(d));
        check({tag, ".flags"}, 64'(rd_flags_o), 64'(fl));
        check({tag, ".cnt"},   64'(inflight_cnt_o), 64'(cnt));
    endtask

    initial begin
        rst = 1'b1; stall_i = 1'b0; squash_i = 1'b0;
        rs1_q_i = 5'd0; rs2_q_i = 5'd0;
        issue(2'b00, 32'h1234, 32'h5678, 5'd3);
        step();
        rst = 1'b0;
        idle();
        check_out("reset", 1'b0, 5'd0, 32'd0, 32'd0, 2'd0);
        check("reset.hazard", 64'(hazard_o), 64'd0);

        // MUL: -3 * 7 = -21
        issue(2'b00, 32'hFFFF_FFFD, 32'd7, 5'd5);
        step(); idle();
        check_out("mul.c1", 1'b0, 5'd0, 32'd0, 32'h20, 2'd1);
        step();
        check_out("mul.c2", 1'b0, 5'd0, 32'd0, 32'h20, 2'd2 - 2'd1);
        step();
        check_out("mul.c3", 1'b1, 5'd5, 32'hFFFF_FFEB, 32'h20, 2'd1);
        step();
        check_out("mul.c4", 1'b0, 5'd0, 32'd0, 32'd0, 2'd0);

        // High variants back to back
        issue(2'b01, 32'h8000_0000, 32'h8000_0000, 5'd1); step();
        issue(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2); step();
        issue(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3); step();
        idle();
        check_out("mulh",   1'b1, 5'd1, 32'h4000_0000, 32'h0E, 2'd3);
        step();
        check_out("mulhsu", 1'b1, 5'd2, 32'hFFFF_FFFF, 32'h0C, 2'd2);
        step();
        check_out("mulhu",  1'b1, 5'd3, 32'hFFFF_FFFE, 32'h08, 2'd1);
        step();
        check_out("high.drain", 1'b0, 5'd0, 32'd0, 32'd0, 2'd0);

        // Stall mid-flight, with an issue attempt that must be ignored
        issue(2'b00, 32'd6, 32'd7, 5'd9); step();
        idle(); step();
        stall_i = 1'b1;
        issue(2'b00, 32'd2, 32'd3, 5'd10);
        step();
        check_out("stall.s1", 1'b0, 5'd0, 32'd0, 32'h200, 2'd2 - 2'd1);
        step();
        check_out("stall.s2", 1'b0, 5'd0, 32'd0, 32'h200, 2'd1);
        stall_i = 1'b0;
        idle();
        step();
        check_out("stall.res", 1'b1, 5'd9, 32'h2A, 32'h200, 2'd1);
        stall_i = 1'b1;
        step();
        check_out("stall.hold", 1'b1, 5'd9, 32'h2A, 32'h200, 2'd1);
        stall_i = 1'b0;
        step();
        check_out("stall.drain", 1'b0, 5'd0, 32'd0, 32'd0, 2'd0);

        // Squash and x0 behind an in-flight op
        issue(2'b00, 32'd3, 32'd5, 5'd4); step();
        issue(2'b00, 32'd9, 32'd9, 5'd11); squash_i = 1'b1; step();
        squash_i = 1'b0;
        issue(2'b00, 32'd9, 32'd9, 5'd0); step();
        idle();
        check_out("sq.prev", 1'b1, 5'd4, 32'h0F, 32'h10, 2'd1);
        step();
        check_out("sq.b1", 1'b0, 5'd0, 32'd0, 32'd0, 2'd0);
        step();
        check_out("sq.b2", 1'b0, 5'd0, 32'd0, 32'd0, 2'd0);

        // Squash together with stall: nothing accepted, pipe holds
        stall_i = 1'b1; squash_i = 1'b1;
        issue(2'b00, 32'd1, 32'd1, 5'd12); step();
        stall_i = 1'b0; squash_i = 1'b0; idle();
        step(); step(); step();
        check_out("sqst", 1'b0, 5'd0, 32'd0, 32'd0, 2'd0);

        // Hazard query
        issue(2'b00, 32'd2, 32'd2, 5'd7); step();
        idle();
        rs1_q_i = 5'd7; rs2_q_i = 5'd0; #1;
        check("haz.rs1", 64'(hazard_o), 64'd1);
        rs1_q_i = 5'd0; #1;
        check("haz.zero", 64'(hazard_o), 64'd0);
        rs2_q_i = 5'd7; #1;
        check("haz.rs2", 64'(hazard_o), 64'd1);
        rs1_q_i = 5'd8; rs2_q_i = 5'd6; #1;
        check("haz.other", 64'(hazard_o), 64'd0);
        rs1_q_i = 5'd0; rs2_q_i = 5'd0;
        step(); step();
        check_out("haz.res", 1'b1, 5'd7, 32'd4, 32'h80, 2'd1);
        step();

        // Reset with three ops in flight
        issue(2'b00, 32'd1, 32'd1, 5'd1); step();
        issue(2'b00, 32'd1, 32'd2, 5'd2); step();
        issue(2'b00, 32'd1, 32'd3, 5'd3); step();
        idle();
        check("rst.pre.cnt", 64'(inflight_cnt_o), 64'd3);
        rst = 1'b1; step(); rst = 1'b0;
        check_out("rst.mid", 1'b0, 5'd0, 32'd0, 32'd0, 2'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check_out("rst.after", 1'b0, 5'd0, 32'd0, 32'd0, 2'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mult_pipe_unit.md
# mult_pipe_unit

Parametrised pipelined multiply unit for the RV32M datapath, sitting beside the ALU in EX. It takes operands and destination from the ID/EX register and returns MUL/MULH/MULHSU/MULHU results a fixed number of cycles later. Compared with the previous unit it adds:
- configurable operand width and pipeline depth;
- a global stall input that freezes the pipe;
- issue-slot squash;
- an explicit result-valid output;
- x0 filtering;
- an in-flight counter;
- a combinational hazard query for the stall controller.

## Interface
Parameters:
- XLEN, 32, operand/result width.
- STAGES, 3, pipeline register levels from issue to result (≥1).
- CNT_W, $clog2(STAGES+1), width of inflight_cnt_o.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- use_i  in  1  issue a multiply this cycle.
- mult_type_i  in  2  00 MUL (low), 01 MULH (S×S high), 10 MULHSU (rs1 S × rs2 U high), 11 MULHU (U×U high).
- rs1_data_i  in  XLEN  operand A.
- rs2_data_i  in  XLEN  operand B.
- rd_addr_i  in  5  destination register.
- stall_i  in  1  freeze entire pipe; no issue accepted.
- squash_i  in  1  cancel this cycle's issue only.
- rs1_q_i  in  5  hazard query address 1.
- rs2_q_i  in  5  hazard query address 2.
- valid_o  out  1  result present for writeback this cycle.
- rd_addr_o  out  5  destination of the result; 0 when !valid_o.
- rd_data_o  out  XLEN  result; 0 when !valid_o.
- rd_flags_o  out  32  bit r set iff a valid in-flight op targets r (r≠0).
- hazard_o  out  1  rd_flags_o[rs1_q_i] | rd_flags_o[rs2_q_i].
- inflight_cnt_o  out  CNT_W  number of valid entries across all stages.

## Operation
- Accept rule: accept = use_i & ~stall_i & ~squash_i & (rd_addr_i≠0). Non-accepted cycles insert a bubble (valid 0) when not stalled.
- Sign extension to XLEN+1 bits:
  - A_ext = A[XLEN-1] & (type≠11).
  - B_ext = B[XLEN-1] & ~type[1].
- The signed (XLEN+1)×(XLEN+1) product is computed on accept. Keep bits [2·XLEN-1:0].
- Select at issue:
  - type 00 → bits [XLEN-1:0];
  - otherwise → bits [2·XLEN-1:XLEN].
  - Only XLEN result bits travel down the pipe.
- Each stage k (0..STAGES-1) holds valid[k], rd[k] and data[k]. The output is stage STAGES-1.
- When stall_i=0, every stage shifts by one. Stage 0 loads {accept, rd_addr_i, result}.
- When stall_i=1, all stage registers hold. valid_o, rd_addr_o and rd_data_o stay constant.
- squash_i affects only the issuing op. Ops already in flight are older and always complete.
- rd_flags_o is the OR over k of onehot(rd[k]) & valid[k], including the output stage. Bit 0 is always 0.
- inflight_cnt_o is the popcount of valid[]. Range 0..STAGES.
- hazard_o, rd_flags_o and inflight_cnt_o are combinational from registered state only. They have no path from use_i.

## Timing
- Reset (rst=1 at an edge): all valid, rd and data clear. Next cycle:
  - valid_o=0, rd_addr_o=0, rd_data_o=0;
  - rd_flags_o=0, hazard_o=0, inflight_cnt_o=0.
- Reset overrides stall_i. Ops in flight at reset are discarded.
- Latency: an op accepted at edge N has valid_o=1 in the cycle after edge N+STAGES-1, i.e. STAGES cycles after issue. Each stalled edge in between adds one cycle.
- Throughput: one accept per unstalled cycle. Back-to-back ops emerge on consecutive cycles.
- An op leaves rd_flags_o on the first unstalled edge after its valid_o cycle.
- Simultaneous squash_i & stall_i: no accept, pipe holds.
- Issue with rd_addr_i=0 never asserts valid_o and never sets flags.

## Test plan
- Each test below uses STAGES=3, XLEN=32.
- MUL: issue type 00, A=0xFFFFFFFD (−3), B=7, rd=5 → valid_o=1 exactly 3 cycles later with rd_addr_o=5, rd_data_o=0xFFFFFFEB. rd_flags_o[5]=1 during the 3 in-flight cycles, 0 afterwards.
- High variants, back-to-back on 3 consecutive cycles:
  - MULH 0x80000000×0x80000000 → 0x40000000;
  - MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF;
  - MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
  - Results appear on 3 consecutive cycles; inflight_cnt_o peaks at 3.
- Stall: issue an op, then hold stall_i for 2 cycles mid-flight → result arrives 5 cycles after issue. Outputs and rd_flags_o are frozen during the stall. use_i asserted during the stall is ignored.
- Squash / x0: issue with squash_i=1, then issue with rd_addr_i=0, both with use_i=1 → valid_o never asserts, rd_flags_o stays 0. A preceding in-flight op still completes.
- Hazard: op to rd=7 in flight, rs1_q_i=7 → hazard_o=1. With rs1_q_i=rs2_q_i=0 → hazard_o=0.
- Reset mid-operation: with 3 ops in flight, assert rst for 1 cycle → all outputs 0 next cycle and no stale result emerges afterwards.
